// File: rtl/a_mem_reader_pkg.sv
// Shared constants and reader state encoding for the A-matrix memory.
// The loader uses the same constants, so the memory layout is defined once.
package a_mem_reader_pkg;

   localparam int unsigned ELEM_W        = 7;
   localparam int unsigned WORD_W        = 2 * ELEM_W;
   localparam int unsigned ADDR_W        = 4;
   localparam int unsigned ROWS          = 8;
   localparam int unsigned COLS          = 4;
   localparam int unsigned IDX_W         = 2;
   localparam int unsigned COL_W         = ADDR_W - IDX_W;
   localparam int unsigned ROW_W         = 3;
   localparam int unsigned WORDS_PER_COL = ROWS / 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_WAIT,
      ST_OUT_HI,
      ST_OUT_LO,
      ST_DONE
   } rd_state_e;

endpackage

// File: rtl/a_mem_reader_word_unpack.sv
// Captures one memory word and presents its high element, then its low element.
module a_word_unpack
   import a_mem_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              advance,
   input  logic [WORD_W-1:0] r_data,
   output logic [ELEM_W-1:0] elem_data,
   output logic              row_lsb
);

   logic [ELEM_W-1:0] lo_q;

   // High half goes straight out; low half waits for the first handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lo_q      <= '0;
         elem_data <= '0;
         row_lsb   <= 1'b0;
      end else if (capture) begin
         lo_q      <= r_data[ELEM_W-1:0];
         elem_data <= r_data[WORD_W-1:ELEM_W];
         row_lsb   <= 1'b0;
      end else if (advance) begin
         elem_data <= lo_q;
         row_lsb   <= 1'b1;
      end
   end

endmodule

// File: rtl/a_mem_reader.sv
// Reads one column (4 packed words) of the A memory and streams its 8 elements
// in row order over a valid/ready handshake.
module a_mem_reader
   import a_mem_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_done,
   input  logic              start,
   input  logic [COL_W-1:0]  col_sel,
   output logic              r_en,
   output logic [ADDR_W-1:0] r_addr,
   input  logic [WORD_W-1:0] r_data,
   output logic [ELEM_W-1:0] elem_data,
   output logic [ROW_W-1:0]  elem_row,
   output logic              elem_valid,
   input  logic              elem_ready,
   output logic              busy,
   output logic              col_done,
   output logic              start_err
);

   rd_state_e        state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             hs, capture, advance, row_lsb;
   logic             r_en_d, busy_d, valid_d, done_d, err_d;

   assign hs       = elem_valid && elem_ready;
   assign r_addr   = {col_q, idx_q};
   assign elem_row = {idx_q, row_lsb};

   a_word_unpack u_unpack (
      .clk       (clk),
      .rst       (rst),
      .capture   (capture),
      .advance   (advance),
      .r_data    (r_data),
      .elem_data (elem_data),
      .row_lsb   (row_lsb)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         col_q      <= '0;
         idx_q      <= '0;
         r_en       <= 1'b0;
         busy       <= 1'b0;
         elem_valid <= 1'b0;
         col_done   <= 1'b0;
         start_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         idx_q      <= idx_d;
         r_en       <= r_en_d;
         busy       <= busy_d;
         elem_valid <= valid_d;
         col_done   <= done_d;
         start_err  <= err_d;
      end
   end

   // Next state; registered outputs are decoded from the next state so they
   // line up with the state they describe.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      idx_d   = idx_q;
      capture = 1'b0;
      advance = 1'b0;
      err_d   = start && ((state_q != ST_IDLE) || !load_done);

      if ((state_q != ST_IDLE) && !load_done) begin
         state_d = ST_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && load_done) begin
                  col_d   = col_sel;
                  idx_d   = '0;
                  state_d = ST_RD_ADDR;
               end
            end
            ST_RD_ADDR: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
               capture = 1'b1;
               state_d = ST_OUT_HI;
            end
            ST_OUT_HI: begin
               if (hs) begin
                  advance = 1'b1;
                  state_d = ST_OUT_LO;
               end
            end
            ST_OUT_LO: begin
               if (hs) begin
                  if (idx_q == IDX_W'(WORDS_PER_COL - 1)) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = ST_RD_ADDR;
                  end
               end
            end
            ST_DONE: begin
               idx_d   = '0;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      r_en_d  = (state_d == ST_RD_ADDR);
      busy_d  = (state_d != ST_IDLE);
      valid_d = (state_d == ST_OUT_HI) || (state_d == ST_OUT_LO);
      done_d  = (state_d == ST_DONE);
   end

endmodule

// File: tb/tb_a_mem_reader.sv
// Bench for a_mem_reader: transaction-level column model plus directed and random stimulus.
module tb_a_mem_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_done = 1'b0;
   logic        start = 1'b0;
   logic        elem_ready = 1'b0;
   logic [1:0]  col_sel = '0;
   logic        r_en;
   logic [3:0]  r_addr;
   logic [13:0] r_data = '0;
   logic [6:0]  elem_data;
   logic [2:0]  elem_row;
   logic        elem_valid, busy, col_done, start_err;

   always #5 clk = ~clk;

   a_mem_reader dut (
      .clk        (clk),
      .rst        (rst),
      .load_done  (load_done),
      .start      (start),
      .col_sel    (col_sel),
      .r_en       (r_en),
      .r_addr     (r_addr),
      .r_data     (r_data),
      .elem_data  (elem_data),
      .elem_row   (elem_row),
      .elem_valid (elem_valid),
      .elem_ready (elem_ready),
      .busy       (busy),
      .col_done   (col_done),
      .start_err  (start_err)
   );

   logic [13:0] mem [16];
   always @(posedge clk) if (r_en) r_data <= mem[r_addr];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of the column's pending elements plus a few counters.
   typedef struct { int row; int data; } el_t;
   el_t         m_q[$];
   el_t         m_e;
   bit          m_active = 0, m_done_pend = 0, m_valid = 0;
   bit          m_r_en = 0, m_done = 0, m_err = 0, m_odd = 0;
   int          m_fetch = 0, m_addr = 0, m_col = 0;
   logic [13:0] m_word;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active = 0; m_done_pend = 0; m_valid = 0;
         m_r_en = 0; m_done = 0; m_err = 0; m_fetch = 0;
         m_q.delete();
      end else begin
         m_r_en = 0;
         m_done = 0;
         m_err  = start && (m_active || !load_done);
         if (m_active) begin
            if (!load_done) begin
               m_active = 0; m_valid = 0; m_fetch = 0; m_done_pend = 0;
               m_q.delete();
            end else if (m_done_pend) begin
               m_active = 0; m_done_pend = 0;
            end else if (m_fetch > 0) begin
               m_fetch--;
               if (m_fetch == 0) m_valid = 1;
            end else if (m_valid && elem_ready) begin
               m_odd = (m_q[0].row % 2) == 1;
               void'(m_q.pop_front());
               if (m_odd) begin
                  m_valid = 0;
                  if (m_q.size() == 0) begin
                     m_done = 1; m_done_pend = 1;
                  end else begin
                     m_r_en = 1; m_fetch = 2;
                     m_addr = m_col * 4 + (8 - m_q.size()) / 2;
                  end
               end
            end
         end else if (start && load_done) begin
            m_col = int'(col_sel);
            for (int w = 0; w < 4; w++) begin
               m_word = mem[4'(m_col * 4 + w)];
               m_e.row = 2 * w;     m_e.data = int'(m_word[13:7]); m_q.push_back(m_e);
               m_e.row = 2 * w + 1; m_e.data = int'(m_word[6:0]);  m_q.push_back(m_e);
            end
            m_active = 1; m_r_en = 1; m_fetch = 2; m_addr = m_col * 4;
         end
      end
   end

   // Per-cycle compare and event log, sampled mid-cycle.
   int ncyc = 0;
   int addr_log[$], row_log[$], data_log[$], done_log[$];
   int err_cnt = 0;

   always @(negedge clk) begin
      ncyc++;
      if (!rst) begin
         check("reset busy", int'(busy), 0);
         check("reset r_en", int'(r_en), 0);
         check("reset r_addr", int'(r_addr), 0);
         check("reset elem_valid", int'(elem_valid), 0);
         check("reset elem_data", int'(elem_data), 0);
         check("reset elem_row", int'(elem_row), 0);
         check("reset col_done", int'(col_done), 0);
         check("reset start_err", int'(start_err), 0);
      end else begin
         check("busy", int'(busy), int'(m_active));
         check("r_en", int'(r_en), int'(m_r_en));
         if (m_r_en) check("r_addr", int'(r_addr), m_addr);
         check("elem_valid", int'(elem_valid), int'(m_valid));
         if (m_valid && m_q.size() > 0) begin
            check("elem_row", int'(elem_row), m_q[0].row);
            check("elem_data", int'(elem_data), m_q[0].data);
         end
         check("col_done", int'(col_done), int'(m_done));
         check("start_err", int'(start_err), int'(m_err));
         if (r_en) addr_log.push_back(int'(r_addr));
         if (elem_valid && elem_ready) begin
            row_log.push_back(int'(elem_row));
            data_log.push_back(int'(elem_data));
         end
         if (col_done) done_log.push_back(ncyc);
         if (start_err) err_cnt++;
      end
   end

   int s_cyc = 0;
   int exp_data[8];
   int col1_data[8] = '{1, 2, 3, 3, 5, 4, 7, 5};

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      addr_log.delete(); row_log.delete(); data_log.delete(); done_log.delete();
      err_cnt = 0;
   endtask

   task automatic start_col(input int c);
      start = 1'b1;
      col_sel = 2'(c);
      tick(1);
      start = 1'b0;
      s_cyc = ncyc;
   endtask

   task automatic exp_from_mem(input int c);
      for (int w = 0; w < 4; w++) begin
         exp_data[2*w]   = int'(mem[4'(c * 4 + w)] >> 7);
         exp_data[2*w+1] = int'(mem[4'(c * 4 + w)] & 14'h7f);
      end
   endtask

   task automatic check_logs(input string tag, input int base, input int n_addr, input int n_el);
      check({tag, " addr count"}, addr_log.size(), n_addr);
      for (int i = 0; i < addr_log.size() && i < n_addr; i++)
         check({tag, " addr"}, addr_log[i], base + i);
      check({tag, " elem count"}, row_log.size(), n_el);
      for (int i = 0; i < row_log.size() && i < n_el; i++) begin
         check({tag, " row"}, row_log[i], i);
         check({tag, " data"}, data_log[i], exp_data[i]);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 14'($urandom);
      mem[4] = 14'h0082; mem[5] = 14'h0183; mem[6] = 14'h0284; mem[7] = 14'h0385;
      tick(3);
      rst = 1'b1;
      load_done = 1'b1;
      elem_ready = 1'b1;
      tick(2);

      // Basic column-1 read with ready tied high.
      clear_logs();
      start_col(1);
      tick(20);
      exp_data = col1_data;
      check_logs("basic", 4, 4, 8);
      check("basic done count", done_log.size(), 1);
      if (done_log.size() > 0) check("basic done latency", done_log[0] - s_cyc, 17);

      // Backpressure on row 2 for three cycles.
      clear_logs();
      start_col(1);
      tick(6);
      elem_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall valid", int'(elem_valid), 1);
         check("stall row", int'(elem_row), 2);
         check("stall data", int'(elem_data), 3);
         @(posedge clk); #1;
      end
      elem_ready = 1'b1;
      tick(14);
      check_logs("stall", 4, 4, 8);
      check("stall done count", done_log.size(), 1);
      if (done_log.size() > 0) check("stall done latency", done_log[0] - s_cyc, 20);

      // Start rejected while the loader has not finished.
      clear_logs();
      load_done = 1'b0;
      start_col(2);
      tick(5);
      check("nold err count", err_cnt, 1);
      check("nold busy", int'(busy), 0);
      check("nold r_en count", addr_log.size(), 0);
      load_done = 1'b1;
      tick(1);

      // Start rejected while a column-1 read is running.
      clear_logs();
      start_col(1);
      tick(3);
      start = 1'b1; col_sel = 2'd2;
      tick(1);
      start = 1'b0;
      tick(20);
      check("busy start err count", err_cnt, 1);
      check_logs("busy start", 4, 4, 8);
      check("busy start done count", done_log.size(), 1);

      // Abort after row 3, then read column 3.
      clear_logs();
      start_col(1);
      tick(8);
      load_done = 1'b0;
      tick(1);
      check("abort busy", int'(busy), 0);
      check("abort valid", int'(elem_valid), 0);
      load_done = 1'b1;
      tick(10);
      check("abort done count", done_log.size(), 0);
      check_logs("abort", 4, 3, 4);
      clear_logs();
      start_col(3);
      tick(20);
      exp_from_mem(3);
      check_logs("col3", 12, 4, 8);
      check("col3 done count", done_log.size(), 1);

      // Asynchronous reset in the middle of OUT_HI.
      clear_logs();
      start_col(1);
      tick(2);
      elem_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("async busy", int'(busy), 0);
      check("async valid", int'(elem_valid), 0);
      check("async data", int'(elem_data), 0);
      check("async row", int'(elem_row), 0);
      check("async r_addr", int'(r_addr), 0);
      tick(2);
      rst = 1'b1;
      elem_ready = 1'b1;
      clear_logs();
      start_col(0);
      tick(20);
      exp_from_mem(0);
      check_logs("post reset", 0, 4, 8);
      check("post reset done count", done_log.size(), 1);

      // Random traffic against the model.
      for (int i = 0; i < 16; i++) mem[i] = 14'($urandom);
      clear_logs();
      repeat (1500) begin
         start      = ($urandom % 8) == 0;
         col_sel    = 2'($urandom);
         elem_ready = ($urandom % 4) != 0;
         load_done  = ($urandom % 50) != 0;
         tick(1);
      end
      start = 1'b0; load_done = 1'b1; elem_ready = 1'b1;
      tick(30);
      check("random columns completed", int'(done_log.size() > 0), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
